// File: rtl/ls_pkg.sv
// Shared types and constants for the SPU local-store pipeline: opcodes, formats,
// the decoded operation kind and the writeback stage entry.
package ls_pkg;

    typedef logic [0:127] qword_t;

    typedef enum logic [1:0] {
        LS_NONE,
        LS_LOAD,
        LS_STORE
    } ls_op_e;

    localparam logic [2:0]  FMT_RR   = 3'd0;
    localparam logic [2:0]  FMT_RI10 = 3'd4;
    localparam logic [2:0]  FMT_RI16 = 3'd5;

    localparam logic [10:0] OP_LQX  = 11'b00111000100;
    localparam logic [10:0] OP_STQX = 11'b00101000100;
    localparam logic [7:0]  OP_LQD  = 8'b00110100;
    localparam logic [7:0]  OP_STQD = 8'b00100100;
    localparam logic [8:0]  OP_LQA  = 9'b001100001;
    localparam logic [8:0]  OP_STQA = 9'b001000001;

    typedef struct packed {
        qword_t     rt;
        logic [6:0] rt_addr;
        logic       we;
        logic       fault;
    } stage_t;

    function automatic logic [31:0] sext14(input logic [13:0] v);
        return {{18{v[13]}}, v};
    endfunction

    function automatic logic [31:0] sext18(input logic [17:0] v);
        return {{14{v[17]}}, v};
    endfunction

endpackage

// File: rtl/ls_delay_line.sv
// Fixed-depth shift register of stage entries that carries load results from
// issue to writeback; synchronous reset empties every stage.
module ls_delay_line
    import ls_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic   clk,
    input  logic   reset,
    input  stage_t in_i,
    output stage_t out_o
);

    stage_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ls_pipe_unit.sv
// SPU local store with odd-pipe load/store unit and a low-priority DMA port.
// Define LS_BOUNDS_CHK_EN to fault SPU accesses whose EA lies beyond the store.
module ls_pipe_unit
    import ls_pkg::*;
#(
    parameter int LS_BYTES   = 32768,
    parameter int LOAD_LAT   = 6,
    parameter int DMA_STARVE = 8,
    localparam int LS_AW     = $clog2(LS_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:10]      op_i,
    input  logic [2:0]       format_i,
    input  logic [6:0]       rt_addr_i,
    input  qword_t           ra_i,
    input  qword_t           rb_i,
    input  qword_t           rt_st_i,
    input  logic [0:17]      imm_i,
    input  logic             reg_write_i,
    input  logic             branch_taken_i,
    output logic             lsu_stall_o,
    output qword_t           rt_wb_o,
    output logic [6:0]       rt_addr_wb_o,
    output logic             reg_write_wb_o,
    output logic             ls_fault_o,
    input  logic             dma_req_i,
    input  logic             dma_we_i,
    input  logic [LS_AW-1:0] dma_addr_i,
    input  qword_t           dma_wdata_i,
    output logic             dma_gnt_o,
    output logic             dma_rvalid_o,
    output qword_t           dma_rdata_o
);

    localparam int IW = LS_AW - 4;
    localparam int SW = $clog2(DMA_STARVE + 1);

    qword_t          mem_q [LS_BYTES/16];
    logic [SW-1:0]   starve_q, starve_d;
    logic            dma_rvalid_q;
    qword_t          dma_rdata_q;
    ls_op_e          dec_op, issue_op;
    logic [31:0]     ea;
    logic            oob;
    logic            spu_access;
    logic [IW-1:0]   spu_idx, dma_idx;
    stage_t          entry_d, wb;
    logic            unused_ok;

    always_comb begin
        dec_op = LS_NONE;
        ea     = '0;
        case (format_i)
            FMT_RR: begin
                ea = ra_i[0:31] + rb_i[0:31];
                if (op_i == OP_LQX)       dec_op = LS_LOAD;
                else if (op_i == OP_STQX) dec_op = LS_STORE;
            end
            FMT_RI10: begin
                ea = ra_i[0:31] + sext14({imm_i[8:17], 4'h0});
                if (op_i[3:10] == OP_LQD)       dec_op = LS_LOAD;
                else if (op_i[3:10] == OP_STQD) dec_op = LS_STORE;
            end
            FMT_RI16: begin
                ea = sext18({imm_i[2:17], 2'b00});
                if (op_i[2:10] == OP_LQA)       dec_op = LS_LOAD;
                else if (op_i[2:10] == OP_STQA) dec_op = LS_STORE;
            end
            default: ;
        endcase
    end

`ifdef LS_BOUNDS_CHK_EN
    assign oob       = |ea[31:LS_AW];
    assign unused_ok = ^{ra_i[32:127], rb_i[32:127], imm_i[0:1], dma_addr_i[3:0], ea[3:0]};
`else
    assign oob       = 1'b0;
    assign unused_ok = ^{ra_i[32:127], rb_i[32:127], imm_i[0:1], dma_addr_i[3:0], ea[3:0],
                         ea[31:LS_AW]};
`endif

    assign spu_idx = ea[LS_AW-1:4];
    assign dma_idx = dma_addr_i[LS_AW-1:4];

    // DMA handshake: dma_req_i is held until dma_gnt_o; the transfer is accepted
    // in the grant cycle, and read data follows one cycle later with dma_rvalid_o.
    // A starved requester forces a grant by stalling the SPU for one cycle.
    assign lsu_stall_o = ~reset & dma_req_i & (starve_q == SW'(DMA_STARVE));
    assign issue_op    = (reset || branch_taken_i || lsu_stall_o) ? LS_NONE : dec_op;
    assign spu_access  = (issue_op != LS_NONE);
    assign dma_gnt_o   = ~reset & dma_req_i & ~spu_access;

    always_comb begin
        starve_d = starve_q;
        if (dma_gnt_o)      starve_d = '0;
        else if (dma_req_i) starve_d = starve_q + 1'b1;
    end

    always_comb begin
        entry_d = '0;
        case (issue_op)
            LS_LOAD: begin
                entry_d.rt      = oob ? '0 : mem_q[spu_idx];
                entry_d.rt_addr = rt_addr_i;
                entry_d.we      = reg_write_i & ~oob;
                entry_d.fault   = oob;
            end
            LS_STORE: begin
                entry_d.rt_addr = rt_addr_i;
                entry_d.fault   = oob;
            end
            default: ;
        endcase
    end

    // SPU and DMA never hit the RAM in the same cycle, so one write port suffices.
    always_ff @(posedge clk) begin
        if (issue_op == LS_STORE && !oob) mem_q[spu_idx] <= rt_st_i;
        else if (dma_gnt_o && dma_we_i)   mem_q[dma_idx] <= dma_wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q     <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            dma_rvalid_q <= dma_gnt_o & ~dma_we_i;
            if (dma_gnt_o && !dma_we_i) dma_rdata_q <= mem_q[dma_idx];
        end
    end

    ls_delay_line #(.DEPTH(LOAD_LAT)) u_delay (
        .clk   (clk),
        .reset (reset),
        .in_i  (entry_d),
        .out_o (wb)
    );

    assign rt_wb_o        = wb.rt;
    assign rt_addr_wb_o   = wb.rt_addr;
    assign reg_write_wb_o = wb.we;
    assign ls_fault_o     = wb.fault;
    assign dma_rvalid_o   = dma_rvalid_q;
    assign dma_rdata_o    = dma_rdata_q;

endmodule
